mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width; data memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  holds the MEM/WB register and blocks memory writes.
REQ-005 SHALL have port PCnew_EX  input  32  PC+4 of the instruction in MEM.
REQ-006 SHALL have port out_EX  input  32  ALU result; byte address for loads and stores.
REQ-007 SHALL have port busB_EX  input  32  store data.
REQ-008 SHALL have port RW_EX  input  5  destination register number.
REQ-009 SHALL have ports MemWrite_EX, MemtoReg_EX, RegWrite_EX  input  1 each  store, load-select and register-write controls.
REQ-010 SHALL have port PCnew_WB  output  32  registered PCnew_EX.
REQ-011 SHALL have port busW_WB  output  32  registered write-back value.
REQ-012 SHALL have port RW_WB  output  5  registered destination register.
REQ-013 SHALL have port RegWrite_WB  output  1  registered, qualified register-write enable.
REQ-014 SHALL have port AddrErr_WB  output  1  registered misaligned-access flag.
REQ-015 SHALL have port ErrCount  output  8  saturating count of misaligned accesses.

Function
REQ-016 Each control input SHALL be treated as asserted only when it is exactly 1; X or Z SHALL be treated as 0.
REQ-017 Access SHALL be "memory" when MemWrite_EX=1 or MemtoReg_EX=1.
REQ-018 Access SHALL be "misaligned" when it is a memory access and out_EX[1:0]!=0.
REQ-019 Word index SHALL be out_EX[ADDR_W+1:2]; higher address bits are ignored, so the index wraps modulo 2^ADDR_W.
REQ-020 Memory write SHALL occur at the rising edge when all hold: MemWrite_EX=1, aligned, stall=0, rst=0.
REQ-021 Memory read SHALL be combinational at the word index; read data SHALL be captured into the MEM/WB register at the same edge.
REQ-022 A load and a store to the same word at the same edge SHALL return the pre-write data (read-before-write).
REQ-023 With stall=0 and rst=0, each edge SHALL load: PCnew_WB<=PCnew_EX, RW_WB<=RW_EX, busW_WB<=(MemtoReg_EX ? read data : out_EX).
REQ-024 RegWrite_WB SHALL load RegWrite_EX AND NOT misaligned.
REQ-025 AddrErr_WB SHALL load 1 for a misaligned access, else 0.
REQ-026 Latency SHALL be exactly one cycle from inputs to *_WB outputs.
REQ-027 With stall=1 and rst=0, all *_WB outputs and ErrCount SHALL hold, and no memory write SHALL occur.
REQ-028 ErrCount SHALL increment by 1 on each non-stalled edge with a misaligned access, and SHALL saturate at 255.
REQ-029 A misaligned store SHALL leave memory unchanged.
REQ-030 A misaligned load SHALL still present read data of the truncated index on busW_WB, with RegWrite_WB=0.

Reset
REQ-031 With rst=1 at an edge, PCnew_WB, busW_WB, RW_WB, RegWrite_WB, AddrErr_WB and ErrCount SHALL all become 0.
REQ-032 rst SHALL take priority over stall.
REQ-033 Any store presented in a reset cycle SHALL be dropped.
REQ-034 Memory contents SHALL NOT be cleared by reset; they SHALL be preserved across reset.
REQ-035 Reset asserted mid-stream SHALL discard the in-flight MEM/WB contents.

Verification
REQ-036 Store then load: store busB_EX=0xDEADBEEF at out_EX=0x10; load 0x10 next cycle -> busW_WB=0xDEADBEEF, RegWrite_WB=1, one cycle after the load.
REQ-037 Same-word load and store in one cycle: word 0x20 holds 0x11111111; apply MemWrite_EX=1 and MemtoReg_EX=1 with busB_EX=0x22222222 -> busW_WB=0x11111111; a later load returns 0x22222222.
REQ-038 Misaligned store: store at out_EX=0x12 -> AddrErr_WB=1, RegWrite_WB=0, ErrCount=1, word 0x10 unchanged; 300 further misaligned accesses -> ErrCount=255.
REQ-039 Stall: stall=1 for 3 cycles with MemWrite_EX=1 at 0x30 -> memory unchanged, *_WB outputs held; releasing stall performs the write.
REQ-040 Reset under stall: rst=1 and stall=1 together -> all outputs 0 next edge; data stored before reset remains readable afterwards.
REQ-041 Control X handling: MemWrite_EX=X -> no write, AddrErr_WB=0; MemtoReg_EX=X -> busW_WB=out_EX.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage. It holds a 2^ADDR_W x 32 data memory with a
// combinational read port, flags misaligned accesses, and keeps a saturating
// error counter. Memory contents survive reset; only the stage registers clear.
module mem_wb_stage #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] PCnew_EX,
   input  logic [31:0] out_EX,
   input  logic [31:0] busB_EX,
   input  logic [4:0]  RW_EX,
   input  logic        MemWrite_EX,
   input  logic        MemtoReg_EX,
   input  logic        RegWrite_EX,
   output logic [31:0] PCnew_WB,
   output logic [31:0] busW_WB,
   output logic [4:0]  RW_WB,
   output logic        RegWrite_WB,
   output logic        AddrErr_WB,
   output logic [7:0]  ErrCount
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       r_mem [DEPTH];
   logic [31:0]       r_pc;
   logic [31:0]       r_busw;
   logic [4:0]        r_rw;
   logic              r_rwe;
   logic              r_err;
   logic [7:0]        r_cnt;

   logic              w_memwr;
   logic              w_memrd;
   logic              w_regwr;
   logic              w_mis;
   logic              w_advance;
   logic [ADDR_W-1:0] w_idx;
   logic [31:0]       w_rdata;

   // A control only counts when it is a clean 1; X or Z reads as deasserted.
   assign w_memwr   = (MemWrite_EX === 1'b1);
   assign w_memrd   = (MemtoReg_EX === 1'b1);
   assign w_regwr   = (RegWrite_EX === 1'b1);
   assign w_mis     = (w_memwr | w_memrd) & (out_EX[1:0] != 2'b00);
   assign w_advance = ~rst & ~stall;
   // Upper address bits are dropped, so the word index wraps.
   assign w_idx     = out_EX[ADDR_W+1:2];
   assign w_rdata   = r_mem[w_idx];

   // Memory write port: aligned stores only, never while stalled or in reset.
   // The read above sees the old word, giving read-before-write on a collision.
   always_ff @(posedge clk) begin
      if (w_advance && w_memwr && !w_mis)
         r_mem[w_idx] <= busB_EX;
   end

   // MEM/WB register and error counter; reset beats stall, stall holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc   <= '0;
         r_busw <= '0;
         r_rw   <= '0;
         r_rwe  <= 1'b0;
         r_err  <= 1'b0;
         r_cnt  <= '0;
      end else if (!stall) begin
         r_pc   <= PCnew_EX;
         r_busw <= w_memrd ? w_rdata : out_EX;
         r_rw   <= RW_EX;
         r_rwe  <= w_regwr & ~w_mis;
         r_err  <= w_mis;
         if (w_mis && r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   assign PCnew_WB    = r_pc;
   assign busW_WB     = r_busw;
   assign RW_WB       = r_rw;
   assign RegWrite_WB = r_rwe;
   assign AddrErr_WB  = r_err;
   assign ErrCount    = r_cnt;

endmodule
